// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signals of the load/store unit.
// The master modport is the unit itself; slave is the pipeline plus data memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              cpuReq;
  logic              cpuWrite;
  logic [1:0]        cpuSize;
  logic              cpuSigned;
  logic [ADDR_W-1:0] cpuAddr;
  logic [31:0]       cpuWriteData;
  logic [31:0]       cpuReadData;
  logic              stall;
  logic              done;
  logic              misaligned;
  logic [31:0]       memAddr;
  logic              memRead;
  logic              memWrite;
  logic [31:0]       memWriteData;
  logic [31:0]       memReadData;
  logic              memAck;

  modport master (
    input  cpuReq, cpuWrite, cpuSize, cpuSigned, cpuAddr, cpuWriteData,
    input  memReadData, memAck,
    output cpuReadData, stall, done, misaligned,
    output memAddr, memRead, memWrite, memWriteData
  );

  modport slave (
    output cpuReq, cpuWrite, cpuSize, cpuSigned, cpuAddr, cpuWriteData,
    output memReadData, memAck,
    input  cpuReadData, stall, done, misaligned,
    input  memAddr, memRead, memWrite, memWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: sub-word stores via read-modify-write, extended sub-word loads.
// Latency 1 (misaligned) / 2 (load, word store) / 3 (sub-word store) cycles plus one per cycle memAck is low; stall held meanwhile.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              mis_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              mis_req;
  logic              accept;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ext;
  logic [31:0]       merged;

  assign accept = (state_q == IDLE) && bus.cpuReq;

  always_comb begin
    mis_req = 1'b0;
    case (bus.cpuSize)
      2'b00:   mis_req = 1'b0;
      2'b01:   mis_req = bus.cpuAddr[0];
      2'b10:   mis_req = |bus.cpuAddr[1:0];
      default: mis_req = 1'b1;
    endcase
  end

  // Lane extraction and merge both work on the word as it comes back from memory.
  always_comb begin
    lane_b = bus.memReadData[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
    case (size_q)
      2'b00:   ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: ext = bus.memReadData;
    endcase
  end

  always_comb begin
    merged = bus.memReadData;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpuReq) begin
          if (mis_req)                   state_d = DONE;
          else if (!bus.cpuWrite)        state_d = READ;
          else if (bus.cpuSize == 2'b10) state_d = WRITE;
          else                           state_d = RMW_READ;
        end
      end
      READ:      if (bus.memAck) state_d = DONE;
      WRITE:     if (bus.memAck) state_d = DONE;
      RMW_READ:  if (bus.memAck) state_d = RMW_WRITE;
      RMW_WRITE: if (bus.memAck) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.cpuAddr;
        size_q   <= bus.cpuSize;
        signed_q <= bus.cpuSigned;
        mis_q    <= mis_req;
        wdata_q  <= bus.cpuWriteData;
      end
      if ((state_q == READ) && bus.memAck) begin
        rdata_q <= ext;
      end
      // The merged word replaces the store data so the write phase drives it directly.
      if ((state_q == RMW_READ) && bus.memAck) begin
        wdata_q <= merged;
      end
    end
  end

  assign bus.memAddr      = 32'(addr_q[ADDR_W-1:2]);
  assign bus.memWriteData = wdata_q;
  assign bus.memRead      = (state_q == READ)  || (state_q == RMW_READ);
  assign bus.memWrite     = (state_q == WRITE) || (state_q == RMW_WRITE);
  assign bus.cpuReadData  = rdata_q;
  assign bus.done         = (state_q == DONE);
  assign bus.misaligned   = (state_q == DONE) && mis_q;
  assign bus.stall        = bus.cpuReq && (state_q != DONE);

endmodule
